seq_detector_param: RTL and testbench

Parametrised Moore serial-pattern detector; successor to the fixed single-pattern detectors in the sequence-detection blocks.
- Pattern, length, don't-care mask and overlap/non-overlap mode are configurable at runtime.
- Serial input is qualified by a valid strobe.
- A saturating match counter is included.
- Sits between a serial bit source (deserialiser/UART-rx bit stream) and control logic that reacts to framing or sync words.

---
 rtl/seq_detector_param.sv | 149 ++++++++++++++
 tb/tb_seq_detector_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable Moore serial pattern detector.
// Bits arrive MSB-of-pattern first on din when din_valid is high; detected is a
// registered flag that rises the edge after the last pattern bit and holds
// until the next accepted bit. Pattern, don't-care mask, length and overlap
// mode are latched with cfg_load. A saturating match counter is included.
// Optional feature macro: SEQDET_STICKY_EN adds a sticky match_seen output.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0110,
    parameter int                 DEF_LEN     = 5,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [MAX_LEN-1:0] cfg_mask,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
`ifdef SEQDET_STICKY_EN
    ,
    output logic               match_seen
`endif
);

    logic [MAX_LEN-1:0] hist_q, hist_d, hist_n;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_q, len_d, len_clamped;
    logic [LEN_W-1:0]   fill_q, fill_d, fill_n;
    logic               overlap_q, overlap_d;
    logic               detected_q, detected_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               accept;
    logic               match;
`ifdef SEQDET_STICKY_EN
    logic               seen_q, seen_d;
`endif

    // Window mask: only the low len bits of the history take part in a compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_q) begin
                len_mask[i] = 1'b1;
            end
        end
    end

    // Next-state logic for history, fill level, config, match flag and counter.
    always_comb begin
        accept      = din_valid && !cfg_load;
        hist_n      = {hist_q[MAX_LEN-2:0], din};
        fill_n      = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        match       = accept && (fill_n == len_q) &&
                      (((hist_n ^ pattern_q) & mask_q & len_mask) == '0);

        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end

        hist_d      = hist_q;
        fill_d      = fill_q;
        detected_d  = detected_q;
        pattern_d   = pattern_q;
        mask_d      = mask_q;
        len_d       = len_q;
        overlap_d   = overlap_q;

        if (cfg_load) begin
            pattern_d  = cfg_pattern;
            mask_d     = cfg_mask;
            len_d      = len_clamped;
            overlap_d  = cfg_overlap;
            hist_d     = '0;
            fill_d     = '0;
            detected_d = 1'b0;
        end else if (accept) begin
            hist_d     = hist_n;
            detected_d = match;
            fill_d     = (match && !overlap_q) ? '0 : fill_n;
        end

        count_d = count_q;
        if (count_clr) begin
            count_d = match ? CNT_W'(1) : '0;
        end else if (match && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end

`ifdef SEQDET_STICKY_EN
        seen_d = seen_q;
        if (match) begin
            seen_d = 1'b1;
        end else if (cfg_load || count_clr) begin
            seen_d = 1'b0;
        end
`endif
    end

    // State registers; reset restores the default configuration and clears progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
            pattern_q  <= DEF_PATTERN;
            mask_q     <= '1;
            len_q      <= LEN_W'(DEF_LEN);
            overlap_q  <= DEF_OVERLAP;
`ifdef SEQDET_STICKY_EN
            seen_q     <= 1'b0;
`endif
        end else begin
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            detected_q <= detected_d;
            count_q    <= count_d;
            pattern_q  <= pattern_d;
            mask_q     <= mask_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
`ifdef SEQDET_STICKY_EN
            seen_q     <= seen_d;
`endif
        end
    end

    assign detected    = detected_q;
    assign match_count = count_q;
    assign count_sat   = &count_q;
`ifdef SEQDET_STICKY_EN
    assign match_seen  = seen_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench for seq_detector_param.
// The driver applies directed then random stimulus on the falling edge and
// pushes the reference model's expected outputs; the monitor pops one entry
// after every rising edge and compares. Honours SEQDET_STICKY_EN.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic             det;
        logic [CNT_W-1:0] cnt;
        logic             sat;
        logic             seen;
    } expT;

    logic               clk = 1'b0;
    logic               reset;
    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [MAX_LEN-1:0] cfg_mask;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
`ifdef SEQDET_STICKY_EN
    logic               match_seen;
`endif

    expT scoreboard[$];
    int  testsRun    = 0;
    int  testsFailed = 0;
    bit  drvDone     = 1'b0;

    // Reference model state: config plus the bit history since the last restart.
    bit [MAX_LEN-1:0] mPat;
    bit [MAX_LEN-1:0] mMask;
    int               mLen;
    bit               mOvl;
    bit               mBits[$];
    int               mFresh;
    bit               mDet;
    int               mCnt;
    bit               mSeen;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din_valid  (din_valid),
        .din        (din),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .count_clr  (count_clr),
        .detected   (detected),
        .match_count(match_count),
        .count_sat  (count_sat)
`ifdef SEQDET_STICKY_EN
        ,
        .match_seen (match_seen)
`endif
    );

    always #5 clk = ~clk;

    // True when the newest mLen received bits agree with the pattern on every masked position.
    function automatic bit windowMatches();
        int n = mBits.size();
        for (int j = 0; j < mLen; j++) begin
            if (mMask[j] && (mBits[n-1-j] != mPat[j])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit m = 1'b0;
        if (reset) begin
            mPat = 8'b0001_0110; mMask = '1; mLen = 5; mOvl = 1'b1;
            mBits.delete(); mFresh = 0; mDet = 1'b0; mCnt = 0; mSeen = 1'b0;
            return;
        end
        if (cfg_load) begin
            mPat  = cfg_pattern;
            mMask = cfg_mask;
            mLen  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
            mOvl  = cfg_overlap;
            mBits.delete();
            mFresh = 0;
            mDet   = 1'b0;
        end else if (din_valid) begin
            mBits.push_back(din);
            if (mBits.size() > MAX_LEN) void'(mBits.pop_front());
            mFresh++;
            m    = (mFresh >= mLen) && windowMatches();
            mDet = m;
            if (m && !mOvl) mFresh = 0;
        end
        if (count_clr)                 mCnt = m ? 1 : 0;
        else if (m && mCnt < CNT_MAX)  mCnt++;
        if (m)                         mSeen = 1'b1;
        else if (cfg_load || count_clr) mSeen = 1'b0;
    endtask

    // Drive one cycle of inputs, record the expected response, wait for the next falling edge.
    task automatic applyStimulus(input bit r, input bit v, input bit d, input bit ld, input bit clr);
        expT e;
        reset     = r;
        din_valid = v;
        din       = d;
        cfg_load  = ld;
        count_clr = clr;
        modelStep();
        e.det  = mDet;
        e.cnt  = CNT_W'(mCnt);
        e.sat  = (mCnt == CNT_MAX);
        e.seen = mSeen;
        scoreboard.push_back(e);
        @(negedge clk);
    endtask

    // Feed a list of accepted bits, first element first.
    task automatic sendBits(input bit bits[$]);
        foreach (bits[i]) applyStimulus(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic loadCfg(input bit [MAX_LEN-1:0] p, input bit [MAX_LEN-1:0] mk,
                           input bit [LEN_W-1:0] l, input bit o);
        cfg_pattern = p;
        cfg_mask    = mk;
        cfg_len     = l;
        cfg_overlap = o;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Compare the DUT outputs against one scoreboard entry.
    task automatic checkOutput(input expT e);
        testsRun++;
        if (detected !== e.det) begin
            testsFailed++;
            $display("[TB] FAIL detected: got %0b expected %0b at %0t", detected, e.det, $time);
        end
        testsRun++;
        if (match_count !== e.cnt) begin
            testsFailed++;
            $display("[TB] FAIL match_count: got %0d expected %0d at %0t", match_count, e.cnt, $time);
        end
        testsRun++;
        if (count_sat !== e.sat) begin
            testsFailed++;
            $display("[TB] FAIL count_sat: got %0b expected %0b at %0t", count_sat, e.sat, $time);
        end
`ifdef SEQDET_STICKY_EN
        testsRun++;
        if (match_seen !== e.seen) begin
            testsFailed++;
            $display("[TB] FAIL match_seen: got %0b expected %0b at %0t", match_seen, e.seen, $time);
        end
`endif
    endtask

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        cfg_pattern = '0; cfg_mask = '0; cfg_len = '0; cfg_overlap = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        sendBits('{1, 0, 1, 1, 0, 1, 1, 0});
        sendBits('{1, 0, 1, 1});
        idle(3);
        sendBits('{0});
        idle(4);
        sendBits('{1});

        loadCfg(8'b0001_0110, 8'hFF, 4'd5, 1'b0);
        sendBits('{1, 0, 1, 1, 0, 1, 1, 0});

        loadCfg(8'b0000_0101, 8'b0000_0101, 4'd3, 1'b1);
        sendBits('{1, 1, 1, 0, 0, 1});

        loadCfg(8'b0000_0001, 8'h01, 4'd1, 1'b0);
        sendBits('{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1});
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        loadCfg(8'hA5, 8'h00, 4'd0, 1'b1);
        sendBits('{0, 1, 0});
        loadCfg(8'hFF, 8'hFF, 4'd15, 1'b1);
        sendBits('{1, 1, 1, 1, 1, 1, 1, 1, 1});

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sendBits('{1, 0, 1});
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        sendBits('{1, 0, 1, 1, 0});

        for (int i = 0; i < 3000; i++) begin
            bit r, v, d, ld, clr;
            r   = ($urandom_range(0, 299) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            cfg_pattern = MAX_LEN'($urandom);
            cfg_mask    = ($urandom_range(0, 3) == 0) ? '0 : MAX_LEN'($urandom);
            cfg_len     = ($urandom_range(0, 1) == 0) ? LEN_W'($urandom_range(1, 4))
                                                      : LEN_W'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom_range(0, 1));
            applyStimulus(r, v, d, ld, clr);
        end
        drvDone = 1'b1;
    end

    // Monitor: after every rising edge pop one expectation and compare.
    initial begin
        while (!drvDone || scoreboard.size() > 0) begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog in case the run stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d entries pending", scoreboard.size());
        $fatal(1, "[TB] timeout");
    end

endmodule
